// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid byte input into a power-of-2 FIFO,
// serialised LSB-first onto an idle-high line with no gap between queued frames.
//   state  | meaning
//   IDLE   | line high, waiting for a queued byte
//   START  | start bit (low) for one symbol
//   DATA   | eight data bits, LSB first
//   STOP   | stop bit (high); pops straight into START if more bytes are queued
module uart_tx_buffered #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_EDGE_TIME - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_serial;

  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [2:0]    w_next_idx;

  assign data_in_ready = (r_count < DEPTH_L);
  assign w_push        = data_in_valid && data_in_ready;
  assign w_bit_end     = (r_bit_cnt == CNT_LAST);
  // Pop only when the shifter is being (re)loaded: from IDLE, or at the end of a stop bit.
  assign w_pop         = (r_count != '0) &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_next_idx    = r_bit_idx + 3'd1;

  assign serial_out = r_serial;
  assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);
  assign fifo_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_serial  <= 1'b1;
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_state  <= S_START;
            r_serial <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
            r_serial  <= r_shift[0];
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state  <= S_STOP;
              r_serial <= 1'b1;
            end else begin
              r_bit_idx <= w_next_idx;
              r_serial  <= r_shift[w_next_idx];
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift  <= r_mem[r_rd_ptr];
              r_state  <= S_START;
              r_serial <= 1'b0;
            end else begin
              r_state  <= S_IDLE;
              r_serial <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 50 clocks/bit; a mid-bit line decoder
// collects frames, start times and framing errors for comparison against hand-derived values.
module tb_uart_tx_buffered;

  localparam int BIT  = 50;
  localparam int HALF = 25;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;
  logic [3:0] fifo_count;

  uart_tx_buffered #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (1_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // line decoder
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;
  bit         m_active  = 0;
  int         m_start   = 0;
  logic [7:0] m_byte;
  int         m_off;
  int         m_k;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_active = 0;
    end else if (!m_active) begin
      if (serial_out == 1'b0) begin
        m_active = 1;
        m_start  = cyc;
      end
    end else begin
      m_off = cyc - m_start;
      if (m_off % BIT == HALF) begin
        m_k = m_off / BIT;
        if (m_k == 0) begin
          if (serial_out !== 1'b0) frame_err++;
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = serial_out;
        end else begin
          if (serial_out !== 1'b1) frame_err++;
          rx_q.push_back(m_byte);
          start_q.push_back(m_start);
          m_active = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the accepting edge, valid left high.
  task automatic push_byte(input logic [7:0] b, output int acc_cyc);
    logic rdy;
    bit   done;
    done = 0;
    acc_cyc = -1;
    data_in = b;
    data_in_valid = 1'b1;
    for (int g = 0; g < 2000 && !done; g++) begin
      rdy = data_in_ready;
      @(negedge clk);
      if (rdy) begin
        done = 1;
        acc_cyc = cyc;
      end
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int g = 0; g < budget && rx_q.size() < n; g++) @(negedge clk);
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  int         a0, a1, s, sent, bad;
  int         acc[10];
  logic       rdy;
  logic [7:0] lfsr;
  logic [7:0] exp_q[$];

  initial begin
    rst = 1'b1;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    #2;
    check("rst_serial", serial_out, 1);
    check("rst_ready", data_in_ready, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_count", fifo_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte
    push_byte(8'hA5, a0);
    data_in_valid = 1'b0;
    check("t1_e0_serial", serial_out, 1);
    check("t1_e0_count", fifo_count, 1);
    @(negedge clk);
    s = cyc;
    check("t1_e1_serial", serial_out, 0);
    check("t1_e1_count", fifo_count, 0);
    check("t1_e1_busy", tx_busy, 1);
    wait_until(s + 10*BIT - 1);
    check("t1_stop_busy", tx_busy, 1);
    check("t1_stop_serial", serial_out, 1);
    @(negedge clk);
    check("t1_end_busy", tx_busy, 0);
    check("t1_end_serial", serial_out, 1);
    check("t1_nrx", rx_q.size(), 1);
    if (rx_q.size() >= 1) begin
      check("t1_byte", rx_q[0], 8'hA5);
      check("t1_start", start_q[0], s);
    end
    check("t1_ferr", frame_err, 0);
    clear_rx();

    // 2: back-to-back
    @(negedge clk);
    push_byte(8'h00, a0);
    push_byte(8'hFF, a1);
    push_byte(8'h55, a1);
    data_in_valid = 1'b0;
    check("t2_count", fifo_count, 2);
    s = a0 + 1;
    wait_until(s + 30*BIT - 1);
    check("t2_last_busy", tx_busy, 1);
    @(negedge clk);
    check("t2_end_busy", tx_busy, 0);
    wait_rx(3, 100);
    if (rx_q.size() == 3) begin
      check("t2_b0", rx_q[0], 8'h00);
      check("t2_b1", rx_q[1], 8'hFF);
      check("t2_b2", rx_q[2], 8'h55);
      check("t2_s0", start_q[0], s);
      check("t2_s1", start_q[1], s + 10*BIT);
      check("t2_s2", start_q[2], s + 20*BIT);
    end
    check("t2_ferr", frame_err, 0);
    clear_rx();

    // 3: backpressure
    @(negedge clk);
    data_in = 8'h01;
    data_in_valid = 1'b1;
    sent = 0;
    for (int g = 0; g < 3000 && sent < 10; g++) begin
      rdy = data_in_ready;
      @(negedge clk);
      if (rdy) begin
        acc[sent] = cyc;
        sent++;
        if (sent == 9) begin
          check("t3_full_ready", data_in_ready, 0);
          check("t3_full_count", fifo_count, 8);
        end
        if (sent < 10) data_in = 8'(sent + 1);
        else data_in_valid = 1'b0;
      end
    end
    check("t3_sent", sent, 10);
    if (sent == 10) begin
      check("t3_nine_span", acc[8] - acc[0], 8);
      check("t3_tenth_at", acc[9] - acc[0], 10*BIT + 2);
    end
    wait_rx(10, 6000);
    bad = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i] !== 8'(i + 1)) bad++;
      if (i > 0 && start_q[i] - start_q[i-1] != 10*BIT) bad++;
    end
    check("t3_stream_bad", bad, 0);
    check("t3_ferr", frame_err, 0);
    wait_until(start_q.size() > 0 ? start_q[start_q.size()-1] + 10*BIT + 1 : cyc);
    check("t3_idle_busy", tx_busy, 0);
    clear_rx();

    // 4: valid low ignored
    data_in = 8'h3C;
    data_in_valid = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || fifo_count !== 4'd0) bad++;
    end
    check("t4_bad", bad, 0);
    check("t4_nrx", rx_q.size(), 0);

    // 5: reset mid-frame
    push_byte(8'h0F, a0);
    push_byte(8'hF0, a1);
    data_in_valid = 1'b0;
    s = a0 + 1;
    wait_until(s + 120);
    check("t5_pre_count", fifo_count, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_serial", serial_out, 1);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_rx();
    @(negedge clk);
    check("t5_post_serial", serial_out, 1);
    push_byte(8'h81, a0);
    data_in_valid = 1'b0;
    wait_rx(1, 700);
    repeat (600) @(negedge clk);
    check("t5_nrx", rx_q.size(), 1);
    if (rx_q.size() >= 1) check("t5_byte", rx_q[0], 8'h81);
    check("t5_ferr", frame_err, 0);
    check("t5_busy", tx_busy, 0);
    clear_rx();

    // 6: 64-byte stream
    lfsr = 8'hB7;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(lfsr);
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    for (int i = 0; i < 64; i++) push_byte(exp_q[i], a0);
    data_in_valid = 1'b0;
    wait_rx(64, 6000);
    bad = 0;
    for (int i = 0; i < 64 && i < rx_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) bad++;
    check("t6_bad", bad, 0);
    if (rx_q.size() == 64) begin
      check("t6_first", rx_q[0], 8'hB7);
      check("t6_last", rx_q[63], exp_q[63]);
    end
    check("t6_ferr", frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter.
- Bytes are pushed over a ready/valid interface into an internal FIFO. The block serialises them LSB-first onto a single idle-high line.
- Drives the CPU `serial_in` pin in system-level benches, acting as host-side stimulus.
- Also usable as the CPU-side TX path when deeper buffering than a single-byte transmitter is needed.

Parameters:
- `CLOCK_FREQ`, 125_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115_200: line rate in bits/s.
- `FIFO_DEPTH`, 8: byte capacity of the FIFO. Must be a power of 2 and ≥ 2.
- Derived localparam `SYMBOL_EDGE_TIME` = `CLOCK_FREQ`/`BAUD_RATE` (integer divide): clocks per bit.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous active-high reset.
- `data_in`, input, 8: byte to transmit.
- `data_in_valid`, input, 1: `data_in` is presented.
- `data_in_ready`, output, 1: FIFO can accept a byte this cycle.
- `serial_out`, output, 1: UART line. Idle high.
- `tx_busy`, output, 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count`, output, $clog2(`FIFO_DEPTH`)+1: bytes currently held in the FIFO, excluding the byte in the shifter.

Behaviour:
- **Reset (async, immediate):**
  - `serial_out`=1, `data_in_ready`=1, `tx_busy`=0, `fifo_count`=0.
  - FSM goes to IDLE. Bit counter, bit index and FIFO pointers are cleared.
  - Reset mid-frame abandons the frame; the line returns high without completing.
  - FIFO contents are discarded.
- **Push:**
  - A handshake is `data_in_valid && data_in_ready` at a rising edge. The byte is written to the FIFO tail.
  - `data_in_ready` = (`fifo_count` < `FIFO_DEPTH`), combinational from registered count.
  - Valid while not ready: no write. The sender must hold the data.
- **Pop:** occurs only when the FSM loads the shifter (see transitions). A pop and a push on the same edge leave `fifo_count` unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:**
    - `serial_out`=1.
    - If `fifo_count` != 0 at an edge: pop the head into the shift register, clear the bit counter, go to START.
  - **START:**
    - `serial_out`=0 for `SYMBOL_EDGE_TIME` clocks.
    - Then go to DATA with bit index 0.
  - **DATA:**
    - `serial_out` = shift[index], LSB first, each bit held `SYMBOL_EDGE_TIME` clocks.
    - After index 7 completes, go to STOP.
  - **STOP:**
    - `serial_out`=1 for `SYMBOL_EDGE_TIME` clocks.
    - At the end of the stop bit: if `fifo_count` != 0, pop and go directly to START (no idle gap between frames); else go to IDLE.
- **Bit counter:** counts 0..`SYMBOL_EDGE_TIME`-1 and wraps at the bit boundary.
- **Frame length:** exactly 10×`SYMBOL_EDGE_TIME` clocks.
- **Latency:** handshake accepted at edge E0 with the FSM in IDLE and the FIFO empty → FIFO non-empty after E0 → pop at E1. `serial_out` is low from E1 (registered output, no glitches).
- **Full FIFO:** 8 stored bytes plus the shifter busy gives 9 bytes in flight. `data_in_ready` rises the cycle after the next pop.
- **`tx_busy`:** equals (state != IDLE) || (`fifo_count` != 0). It is 0 only when the line is idle and nothing is queued.

Test Plan (`CLOCK_FREQ`=50_000_000, `BAUD_RATE`=1_000_000 → 50 clks/bit, `FIFO_DEPTH`=8):
1. **Single byte:** push 0xA5 at edge E0.
   - `serial_out` falls at E1.
   - Sampling mid-bit yields 0 | 1,0,1,0,0,1,0,1 | 1.
   - Line is high and `tx_busy`=0 at E1+500.
2. **Back-to-back:** push 0x00, 0xFF, 0x55 on consecutive cycles.
   - Three contiguous frames totalling 1500 clocks. The next start bit begins on the clock immediately after each stop bit.
   - `fifo_count` reads 2 after the third push.
3. **Backpressure:** hold `data_in_valid` for 10 consecutive bytes 0x01..0x0A.
   - Exactly 9 are accepted in 9 cycles, then `data_in_ready`=0.
   - The 10th is accepted one clock after the first frame's stop bit ends.
   - Decoded stream is 0x01..0x0A in order.
4. **Valid-low ignore:** `data_in`=0x3C with `data_in_valid`=0 for 100 clocks → `serial_out` stays 1, `fifo_count`=0.
5. **Reset mid-frame:** push 0x0F and 0xF0, then assert `rst` at clock 120 of the first frame.
   - `serial_out`=1 immediately.
   - `fifo_count`=0 and the FSM is in IDLE.
   - After release, push 0x81 → one clean frame decoding 0x81; 0xF0 is never sent.
6. **Loopback:** drive `serial_out` into the existing `uart_receiver`. Push 64 pseudo-random bytes → receiver outputs an identical sequence with no framing errors.
